// File: rtl/factorial_arbiter.sv
// rtl/factorial_arbiter.sv - round-robin arbiter sharing one factorial unit among NREQ requesters
// Grants, issues the operand, waits for done under a watchdog, returns the result with an ack pulse.
module factorial_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [4*NREQ-1:0]    req_data,
   output logic [NREQ-1:0]      ack,
   output logic [15:0]          result,
   output logic [IDW-1:0]       result_id,
   output logic                 err,
   output logic                 busy,
   output logic                 fu_start,
   output logic [3:0]           fu_data,
   input  logic                 fu_done,
   input  logic [15:0]          fu_fact
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_t;

   localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

   state_t          state_q;
   logic [IDW-1:0]  rr_ptr_q;
   logic [IDW-1:0]  gnt_q;
   logic [7:0]      wdog_q;
   logic [NREQ-1:0] ack_q;
   logic [15:0]     result_q;
   logic [IDW-1:0]  result_id_q;
   logic            err_q;
   logic            busy_q;
   logic            fu_start_q;
   logic [3:0]      fu_data_q;

   logic [3:0]      req_data_a [NREQ];
   logic            hit_d;
   logic [IDW-1:0]  gnt_d;
   logic [3:0]      op_d;
   logic [IDW-1:0]  idx_d;
   logic [IDW-1:0]  rr_next_d;
   logic [7:0]      wdog_d;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_data_a[i] = req_data[4*i +: 4];
      end
   end

   // First set request bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
   always_comb begin
      hit_d = 1'b0;
      gnt_d = '0;
      op_d  = '0;
      idx_d = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_d = IDW'((int'(rr_ptr_q) + k) % NREQ);
         if (!hit_d && req[idx_d]) begin
            hit_d = 1'b1;
            gnt_d = idx_d;
            op_d  = req_data_a[idx_d];
         end
      end
   end

   assign rr_next_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
   assign wdog_d    = wdog_q + 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         wdog_q      <= '0;
         ack_q       <= '0;
         result_q    <= '0;
         result_id_q <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         fu_start_q  <= 1'b0;
         fu_data_q   <= '0;
      end else begin
         ack_q <= '0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (hit_d) begin
                  gnt_q      <= gnt_d;
                  fu_data_q  <= op_d;
                  fu_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wdog_q  <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving in the same cycle the watchdog expires still wins.
               if (fu_done) begin
                  result_q    <= fu_fact;
                  err_q       <= 1'b0;
                  ack_q       <= NREQ'(1) << gnt_q;
                  result_id_q <= gnt_q;
                  fu_start_q  <= 1'b0;
                  state_q     <= ST_RESP;
               end else begin
                  wdog_q <= wdog_d;
                  if (wdog_d == WDOG_LIMIT) begin
                     result_q    <= '0;
                     err_q       <= 1'b1;
                     ack_q       <= NREQ'(1) << gnt_q;
                     result_id_q <= gnt_q;
                     fu_start_q  <= 1'b0;
                     state_q     <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               rr_ptr_q <= rr_next_d;
               state_q  <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Level done must fall before the next grant so it cannot complete it.
               if (!fu_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               fu_start_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign result    = result_q;
   assign result_id = result_id_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign fu_start  = fu_start_q;
   assign fu_data   = fu_data_q;

endmodule
